sha512_compress: RTL and testbench
==================================

Name: sha512_compress

Overview:
- Downstream neighbour of the message-schedule unit: consumes its 64-bit W_t stream, 80 words per 1024-bit block, and runs the SHA-512 compression rounds.
- Keeps the working variables a..h and the chaining value H0..H7, with feed-forward after every block.
- Emits the 512-bit digest as a single AXI-Stream beat after the final block of each message.
- Sits between the schedule unit and the output/packetising stage of the sha2 datapath.

Parameters:
- C_S_AXIS_DATA_WIDTH, 64, W_t word width; only 64 is supported.
- C_M_AXIS_DATA_WIDTH, 512, digest width; only 512 is supported.
- C_AXIS_TUSER_WIDTH, 128, sideband width, passed from message to digest.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high.
- s_axis_tdata  in  64  W_t, word t of the current block.
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  message sideband; sampled on the first word of a message.
- s_axis_tvalid  in  1  W_t valid.
- s_axis_tready  out  1  ready to accept W_t.
- s_axis_tlast  in  1  set on word t=79 of the final block of a message.
- m_axis_tdata  out  512  digest, H0 in bits [511:448] down to H7 in [63:0].
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  sideband captured for this message.
- m_axis_tvalid  out  1  digest valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  always 1 whenever m_axis_tvalid=1 (single-beat packet).

Behaviour:
- Reset: synchronous, active-high, clocked on clk.
  - While reset=1: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0.
  - State goes to IDLE, t=0, H and a..h load the FIPS 180-4 SHA-512 initial values.
  - First cycle after reset deasserts: s_axis_tready=1.
- States: IDLE, ROUND, FEEDFWD, OUTPUT.
- IDLE: tready=1. On a handshake, capture tuser, run round t=0, set t=1, go to ROUND.
- ROUND: tready=1. Each handshake performs one round using K[t] and W_t, then increments t.
  - The handshake at t=79 goes to FEEDFWD and latches last_blk=s_axis_tlast.
  - Without a handshake, state and t hold (bubbles allowed).
- FEEDFWD: one cycle, tready=0.
  - H_i <= H_i + working variable i, all mod 2^64; a..h <= the new H values.
  - If last_blk=1, go to OUTPUT. Otherwise t=0 and go to ROUND, which is the next block of the same message; tuser is not re-captured.
- OUTPUT: tready=0, m_axis_tvalid=1, tdata holds the final H, tlast=1.
  - tdata/tuser stay stable until the handshake.
  - On m_axis_tready=1: tvalid falls next cycle, H and a..h reload the initial values, go to IDLE.
- Round arithmetic, all additions mod 2^64:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W_t
  - T2 = Σ0(a) + Maj(a,b,c)
  - Update: h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - Σ0 = ROTR28 ^ ROTR34 ^ ROTR39.
  - Σ1 = ROTR14 ^ ROTR18 ^ ROTR41.
  - Ch = (e&f) ^ (~e&g).
  - Maj = (a&b) ^ (a&c) ^ (b&c).
  - One round per cycle; the round is combinational from registered state and the input word.
- Throughput: 81 cycles per block minimum. For an N-block message, m_axis_tvalid rises 1 cycle after the last FEEDFWD.
- s_axis_tlast on any word with t≠79 is ignored. The block boundary is set by the counter alone.
- A stalled OUTPUT holds tready=0; upstream back-pressures and no W_t is lost.
- Reset mid-block or mid-OUTPUT abandons the message immediately; no partial digest is emitted.

Decomposition:
- Shared package sha2_pkg:
  - SHA-512 K[0..79] constant array.
  - H_INIT[0..7] constants.
  - Σ0/Σ1/Ch/Maj functions.
  - State encoding localparams.
- Sub-module sha512_k_rom: combinational lookup of K[t] from the 7-bit t.
- Main module: FSM, counter, a..h/H registers, output register.

Test Plan:
- "abc": 1 block, W_t produced by the reference model, no stalls -> one digest beat ddaf35a193617aba cc417349ae204131 12e6fa4e89a97ea2 0a9eeee64b55d39a 2192992a274fc1a8 36ba3c23a3feebbd 454d4423643ce80e 2a9ac94fa54ca49f, tlast=1, tuser equal to the value presented with word 0; tvalid exactly 81 cycles after the first handshake.
- Empty message, 1 block -> cf83e1357eefb8bd f1542850d66d8007 d620e4050b5715dc 83f4a921d36ce9ce 47d0d13c5d85f2b0 ff8318d2877eec2f 63b931bd47417a81 a538327af927da3e.
- 896-bit "abcdefghbcdefghi…nopqrstu", 2 blocks, tlast only on word 79 of block 2 -> 8e959b75dae313da 8cf4f72814fc143f 8f7779c6eb9f7fa1 7299aeadb6889018 501d289e4900f7e4 331b99dec4b5433a c7d329eeb6dd2654 5e96e55b874be909; no output after block 1.
- Random s_axis_tvalid gaps plus m_axis_tready held low for 20 cycles, with the "abc" input -> same digest; s_axis_tready=0 throughout OUTPUT; tdata stable while stalled; the next message's digest is correct.
- Reset pulsed at t=40 of an "abc" block, then a full "abc" resent -> no digest from the aborted message; the single digest emitted equals the "abc" vector.

Source files
------------

// File: rtl/sha2_pkg.sv
// Shared SHA-512 constants and round helper functions for the sha2 datapath.
package sha2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ROUND   = 2'd1,
        ST_FEEDFWD = 2'd2,
        ST_OUTPUT  = 2'd3
    } state_t;

    localparam int ROUNDS = 80;

    localparam logic [63:0] K [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [63:0] H_INIT [0:7] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [63:0] big_sigma0(input logic [63:0] x);
        return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
    endfunction

    function automatic logic [63:0] big_sigma1(input logic [63:0] x);
        return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
    endfunction

    function automatic logic [63:0] ch(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [63:0] maj(input logic [63:0] x, input logic [63:0] y, input logic [63:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha512_k_rom.sv
// Combinational SHA-512 round-constant lookup indexed by the round counter.
module sha512_k_rom
    import sha2_pkg::*;
(
    input  logic [6:0]  t,
    output logic [63:0] k
);

    always_comb begin
        k = '0;
        if (t < 7'd80) begin
            k = K[t];
        end
    end

endmodule

// File: rtl/sha512_compress.sv
// SHA-512 compression: one round per accepted W_t, feed-forward per block,
// and a single-beat 512-bit digest after the final block of a message.
module sha512_compress
    import sha2_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH = 64,
    parameter int C_M_AXIS_DATA_WIDTH = 512,
    parameter int C_AXIS_TUSER_WIDTH  = 128
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast
);

    state_t                          state_reg, state_next;
    logic [6:0]                      t_reg;
    logic                            last_blk_reg;
    logic [C_AXIS_TUSER_WIDTH-1:0]   tuser_reg;
    // Word 0 is a / H0, word 7 is h / H7.
    logic [7:0][63:0]                wv_reg, h_reg;
    logic [7:0][63:0]                h_init, round_next, ff_sum;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  digest;
    logic [63:0]                     k_t, t1, t2;
    logic                            s_hs, m_hs;

    sha512_k_rom u_k_rom (
        .t (t_reg),
        .k (k_t)
    );

    for (genvar gi = 0; gi < 8; gi++) begin : g_words
        assign h_init[gi] = H_INIT[gi];
        assign ff_sum[gi] = h_reg[gi] + wv_reg[gi];
        assign digest[C_M_AXIS_DATA_WIDTH-1-64*gi -: 64] = h_reg[gi];
    end

    assign t1 = wv_reg[7] + big_sigma1(wv_reg[4]) + ch(wv_reg[4], wv_reg[5], wv_reg[6]) + k_t + s_axis_tdata;
    assign t2 = big_sigma0(wv_reg[0]) + maj(wv_reg[0], wv_reg[1], wv_reg[2]);

    assign round_next[0] = t1 + t2;
    assign round_next[4] = wv_reg[3] + t1;
    for (genvar gi = 1; gi < 8; gi++) begin : g_shift
        if (gi != 4) begin : g_pass
            assign round_next[gi] = wv_reg[gi-1];
        end
    end

    assign s_hs = s_axis_tvalid & s_axis_tready;
    assign m_hs = m_axis_tvalid & m_axis_tready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (s_hs) state_next = ST_ROUND;
            ST_ROUND:   if (s_hs && t_reg == 7'd79) state_next = ST_FEEDFWD;
            ST_FEEDFWD: state_next = last_blk_reg ? ST_OUTPUT : ST_ROUND;
            ST_OUTPUT:  if (m_hs) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Outputs are forced quiet while reset is held, even before the first edge.
    always_comb begin
        s_axis_tready = !reset && (state_reg == ST_IDLE || state_reg == ST_ROUND);
        m_axis_tvalid = !reset && (state_reg == ST_OUTPUT);
        m_axis_tlast  = m_axis_tvalid;
        m_axis_tdata  = m_axis_tvalid ? digest : '0;
        m_axis_tuser  = m_axis_tvalid ? tuser_reg : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_reg        <= '0;
            last_blk_reg <= 1'b0;
            tuser_reg    <= '0;
            wv_reg       <= h_init;
            h_reg        <= h_init;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (s_hs) begin
                        tuser_reg <= s_axis_tuser;
                        wv_reg    <= round_next;
                        t_reg     <= 7'd1;
                    end
                end
                ST_ROUND: begin
                    if (s_hs) begin
                        wv_reg <= round_next;
                        t_reg  <= t_reg + 7'd1;
                        if (t_reg == 7'd79) begin
                            last_blk_reg <= s_axis_tlast;
                        end
                    end
                end
                ST_FEEDFWD: begin
                    h_reg  <= ff_sum;
                    wv_reg <= ff_sum;
                    t_reg  <= '0;
                end
                ST_OUTPUT: begin
                    if (m_hs) begin
                        h_reg  <= h_init;
                        wv_reg <= h_init;
                        t_reg  <= '0;
                    end
                end
                default: t_reg <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_sha512_compress.sv
// Bench for sha512_compress: pads messages, builds W_t, and compares digests
// against a straight-line SHA-512 model and published test vectors.
module tb_sha512_compress;
    import sha2_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [63:0]  s_axis_tdata = '0;
    logic [127:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tready;
    logic         s_axis_tlast = 1'b0;
    logic [511:0] m_axis_tdata;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic         m_axis_tlast;

    always #5 clk = ~clk;

    sha512_compress #(
        .C_S_AXIS_DATA_WIDTH (64),
        .C_M_AXIS_DATA_WIDTH (512),
        .C_AXIS_TUSER_WIDTH  (128)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    typedef struct {
        logic [511:0] data;
        logic [127:0] user;
    } beat_t;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           hs_cyc = 0;
    int           last_rise_cyc = 0;
    int           ready_mode = 0;
    logic [7:0]   msg_q[$];
    logic [63:0]  w_q[$];
    beat_t        got_q[$];
    logic [127:0] cur_user;

    localparam logic [511:0] KAT_ABC = {
        64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
        64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
    localparam logic [511:0] KAT_EMPTY = {
        64'hcf83e1357eefb8bd, 64'hf1542850d66d8007, 64'hd620e4050b5715dc, 64'h83f4a921d36ce9ce,
        64'h47d0d13c5d85f2b0, 64'hff8318d2877eec2f, 64'h63b931bd47417a81, 64'ha538327af927da3e};
    localparam logic [511:0] KAT_896 = {
        64'h8e959b75dae313da, 64'h8cf4f72814fc143f, 64'h8f7779c6eb9f7fa1, 64'h7299aeadb6889018,
        64'h501d289e4900f7e4, 64'h331b99dec4b5433a, 64'hc7d329eeb6dd2654, 64'h5e96e55b874be909};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Pad msg_q per SHA-512 and expand every block into its 80 schedule words.
    function automatic void build_schedule();
        logic [7:0]  p[$];
        logic [63:0] w[80];
        logic [63:0] bits;
        logic [63:0] s0, s1;
        p = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 128 != 112) p.push_back(8'h00);
        for (int i = 0; i < 8; i++) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bits[i*8 +: 8]);
        w_q.delete();
        for (int b = 0; b < p.size() / 128; b++) begin
            for (int i = 0; i < 16; i++) begin
                w[i] = '0;
                for (int j = 0; j < 8; j++) w[i] = {w[i][55:0], p[b*128 + i*8 + j]};
            end
            for (int i = 16; i < 80; i++) begin
                s0 = ref_rotr(w[i-15], 1) ^ ref_rotr(w[i-15], 8) ^ (w[i-15] >> 7);
                s1 = ref_rotr(w[i-2], 19) ^ ref_rotr(w[i-2], 61) ^ (w[i-2] >> 6);
                w[i] = s1 + w[i-7] + s0 + w[i-16];
            end
            for (int i = 0; i < 80; i++) w_q.push_back(w[i]);
        end
    endfunction

    function automatic logic [511:0] model_digest();
        logic [63:0]  hv[8];
        logic [63:0]  v[8];
        logic [63:0]  t1, t2;
        logic [511:0] r;
        for (int i = 0; i < 8; i++) hv[i] = H_INIT[i];
        for (int b = 0; b < w_q.size() / 80; b++) begin
            for (int i = 0; i < 8; i++) v[i] = hv[i];
            for (int t = 0; t < 80; t++) begin
                t1 = v[7] + (ref_rotr(v[4], 14) ^ ref_rotr(v[4], 18) ^ ref_rotr(v[4], 41))
                   + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w_q[b*80 + t];
                t2 = (ref_rotr(v[0], 28) ^ ref_rotr(v[0], 34) ^ ref_rotr(v[0], 39))
                   + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
                for (int j = 7; j > 0; j--) v[j] = v[j-1];
                v[4] = v[4] + t1;
                v[0] = t1 + t2;
            end
            for (int i = 0; i < 8; i++) hv[i] = hv[i] + v[i];
        end
        for (int i = 0; i < 8; i++) r[511 - 64*i -: 64] = hv[i];
        return r;
    endfunction

    function automatic void load_str(input string s);
        msg_q.delete();
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endfunction

    // Presents w_q on the slave port; stop_at >= 0 leaves that word presented and returns.
    task automatic send_words(input int gap_pct, input bit noise, input int stop_at);
        int waited;
        for (int i = 0; i < w_q.size(); i++) begin
            if (i == stop_at) begin
                @(negedge clk);
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = w_q[i];
                s_axis_tlast  = 1'b0;
                return;
            end
            while ($urandom_range(99) < gap_pct) begin
                @(negedge clk);
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = {$urandom, $urandom};
                s_axis_tlast  = 1'($urandom);
            end
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = w_q[i];
            if (i == w_q.size() - 1) s_axis_tlast = 1'b1;
            else if (noise && (i % 80 != 79)) s_axis_tlast = 1'($urandom);
            else s_axis_tlast = 1'b0;
            s_axis_tuser = (i == 0) ? cur_user : {$urandom, $urandom, $urandom, $urandom};
            waited = 0;
            while (!s_axis_tready && waited < 1000) begin
                @(negedge clk);
                waited++;
            end
            if (!s_axis_tready) begin
                check_val("s_ready_timeout", 512'(s_axis_tready), 512'd1);
                return;
            end
            if (i == 0) hs_cyc = cyc;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic run_msg(input string name, input int gap, input bit noise,
                           input bit has_kat, input logic [511:0] kat);
        logic [511:0] exp;
        beat_t        bt;
        int           waited;
        build_schedule();
        exp = model_digest();
        cur_user = {$urandom, $urandom, $urandom, $urandom};
        send_words(gap, noise, -1);
        waited = 0;
        while (got_q.size() == 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (got_q.size() == 0) begin
            check_val({name, "_digest_count"}, 512'(got_q.size()), 512'd1);
        end else begin
            bt = got_q.pop_front();
            check_val({name, "_digest"}, bt.data, exp);
            check_val({name, "_tuser"}, 512'(bt.user), 512'(cur_user));
            if (has_kat) check_val({name, "_vector"}, bt.data, kat);
            check_val({name, "_extra_beats"}, 512'(got_q.size()), 512'd0);
            $display("msg %s bytes=%0d blocks=%0d digest=%h", name, msg_q.size(), w_q.size() / 80, bt.data);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'b0;
            default: m_axis_tready = 1'($urandom);
        endcase
    end

    logic         stall_prev = 1'b0;
    logic         valid_prev = 1'b0;
    logic [511:0] held_data;
    logic [127:0] held_user;

    always @(negedge clk) begin
        if (!reset && m_axis_tvalid) begin
            if (!valid_prev) last_rise_cyc = cyc;
            check_val("s_ready_in_output", 512'(s_axis_tready), 512'd0);
            check_val("m_tlast", 512'(m_axis_tlast), 512'd1);
            if (stall_prev) begin
                check_val("hold_tdata", m_axis_tdata, held_data);
                check_val("hold_tuser", 512'(m_axis_tuser), 512'(held_user));
            end
            held_data  = m_axis_tdata;
            held_user  = m_axis_tuser;
            stall_prev = !m_axis_tready;
            if (m_axis_tready) got_q.push_back('{data: m_axis_tdata, user: m_axis_tuser});
        end else begin
            stall_prev = 1'b0;
        end
        valid_prev = !reset && m_axis_tvalid;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_s_tready", 512'(s_axis_tready), 512'd0);
        check_val("reset_m_tvalid", 512'(m_axis_tvalid), 512'd0);
        check_val("reset_m_tdata", m_axis_tdata, 512'd0);
        check_val("reset_m_tuser", 512'(m_axis_tuser), 512'd0);
        check_val("reset_m_tlast", 512'(m_axis_tlast), 512'd0);
        reset = 1'b0;
        #1;
        check_val("post_reset_s_tready", 512'(s_axis_tready), 512'd1);

        load_str("abc");
        run_msg("abc", 0, 1'b0, 1'b1, KAT_ABC);
        check_val("abc_latency", 512'(last_rise_cyc - hs_cyc), 512'd81);

        load_str("");
        run_msg("empty", 0, 1'b0, 1'b1, KAT_EMPTY);

        load_str({"abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmn",
                  "hijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu"});
        run_msg("two_block", 0, 1'b0, 1'b1, KAT_896);

        load_str("abc");
        ready_mode = 1;
        fork
            begin
                for (int i = 0; i < 5000 && !m_axis_tvalid; i++) @(negedge clk);
                repeat (20) @(negedge clk);
                ready_mode = 0;
            end
        join_none
        run_msg("abc_stalled", 30, 1'b1, 1'b1, KAT_ABC);
        msg_q.delete();
        for (int i = 0; i < 150; i++) msg_q.push_back(8'($urandom));
        run_msg("after_stall", 30, 1'b1, 1'b0, '0);

        // Abort an "abc" block with the round counter at 40.
        load_str("abc");
        build_schedule();
        cur_user = {$urandom, $urandom, $urandom, $urandom};
        send_words(0, 1'b0, 40);
        reset = 1'b1;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        check_val("midreset_s_tready", 512'(s_axis_tready), 512'd0);
        check_val("midreset_m_tvalid", 512'(m_axis_tvalid), 512'd0);
        check_val("midreset_m_tdata", m_axis_tdata, 512'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("midreset_release_tready", 512'(s_axis_tready), 512'd1);
        repeat (120) @(negedge clk);
        check_val("aborted_no_digest", 512'(got_q.size()), 512'd0);
        $display("msg aborted at t=40, digests seen=%0d", got_q.size());
        run_msg("abc_after_abort", 0, 1'b0, 1'b1, KAT_ABC);

        ready_mode = 2;
        for (int m = 0; m < 6; m++) begin
            msg_q.delete();
            for (int i = 0, n = $urandom_range(0, 260); i < n; i++) msg_q.push_back(8'($urandom));
            run_msg($sformatf("random%0d", m), 25, 1'b1, 1'b0, '0);
        end
        ready_mode = 0;

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
